xif_coproc_arbiter: RTL and testbench

Shares the single CORE-V-XIF issue/commit/result channel of the CV32E20 wrapper between `NUM_COPROC` coprocessors. Instructions are offered to the coprocessors one at a time in fixed index order until one accepts. The arbiter records the owner, routes commit to the owner only, and forwards the owner's result back to the CPU. The block sits between `cve2_xif_wrapper` and the coprocessor array. Only one instruction is in flight at a time, matching CVE2.

---
 rtl/xif_coproc_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_xif_coproc_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_coproc_arbiter.sv
// rtl/xif_coproc_arbiter.sv - shares one CORE-V-XIF issue/commit/result channel between NUM_COPROC coprocessors
module xif_coproc_arbiter #(
  parameter int NUM_COPROC = 2,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  // CPU issue side
  input  logic                             cpu_issue_valid_i,
  input  logic [ID_WIDTH-1:0]              cpu_issue_id_i,
  output logic                             cpu_issue_ready_o,
  output logic                             cpu_issue_accept_o,
  output logic                             cpu_issue_writeback_o,
  // coprocessor issue side
  output logic [NUM_COPROC-1:0]            cp_issue_valid_o,
  input  logic [NUM_COPROC-1:0]            cp_issue_ready_i,
  input  logic [NUM_COPROC-1:0]            cp_issue_accept_i,
  input  logic [NUM_COPROC-1:0]            cp_issue_writeback_i,
  // commit
  input  logic                             cpu_commit_valid_i,
  input  logic [ID_WIDTH-1:0]              cpu_commit_id_i,
  input  logic                             cpu_commit_kill_i,
  output logic [NUM_COPROC-1:0]            cp_commit_valid_o,
  // coprocessor result side
  input  logic [NUM_COPROC-1:0]            cp_result_valid_i,
  output logic [NUM_COPROC-1:0]            cp_result_ready_o,
  input  logic [NUM_COPROC*ID_WIDTH-1:0]   cp_result_id_i,
  input  logic [NUM_COPROC*DATA_WIDTH-1:0] cp_result_data_i,
  input  logic [NUM_COPROC*5-1:0]          cp_result_rd_i,
  input  logic [NUM_COPROC-1:0]            cp_result_we_i,
  // CPU result side
  output logic                             cpu_result_valid_o,
  input  logic                             cpu_result_ready_i,
  output logic [ID_WIDTH-1:0]              cpu_result_id_o,
  output logic [DATA_WIDTH-1:0]            cpu_result_data_o,
  output logic [4:0]                       cpu_result_rd_o,
  output logic                             cpu_result_we_o,
  // status
  output logic                             busy_o,
  output logic                             err_o
);

  localparam int IDXW = (NUM_COPROC > 1) ? $clog2(NUM_COPROC) : 1;
  localparam logic [IDXW-1:0]       LAST_IDX = IDXW'(NUM_COPROC - 1);
  localparam logic [NUM_COPROC-1:0] ONE      = NUM_COPROC'(1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    OFFER       = 2'd1,
    COMMIT_WAIT = 2'd2,
    RESULT_WAIT = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [IDXW-1:0]       owner_q, owner_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  err_q, err_d;

  logic [NUM_COPROC-1:0] offer_oh;
  logic [NUM_COPROC-1:0] owner_oh;
  logic                  sel_ready;
  logic                  sel_accept;
  logic                  sel_wb;
  logic                  own_res_valid;
  logic                  stray_res;
  logic [ID_WIDTH-1:0]   own_res_id;

  assign offer_oh      = ONE << idx_q;
  assign owner_oh      = ONE << owner_q;
  assign sel_ready     = cp_issue_ready_i[idx_q];
  assign sel_accept    = cp_issue_accept_i[idx_q];
  assign sel_wb        = cp_issue_writeback_i[idx_q];
  assign own_res_valid = cp_result_valid_i[owner_q];
  // A result from anyone but the owner is never expected while an instruction is in flight
  assign stray_res     = |(cp_result_valid_i & ~owner_oh);
  assign own_res_id    = cp_result_id_i[int'(owner_q)*ID_WIDTH +: ID_WIDTH];

  assign busy_o = (state_q != IDLE);
  assign err_o  = err_q;

  // Next-state and handshake/routing outputs, combinational from state plus same-cycle inputs
  always_comb begin
    state_d               = state_q;
    idx_d                 = idx_q;
    owner_d               = owner_q;
    id_d                  = id_q;
    err_d                 = err_q;
    cpu_issue_ready_o     = 1'b0;
    cpu_issue_accept_o    = 1'b0;
    cpu_issue_writeback_o = 1'b0;
    cp_issue_valid_o      = '0;
    cp_commit_valid_o     = '0;
    cp_result_ready_o     = '0;
    cpu_result_valid_o    = 1'b0;
    cpu_result_id_o       = '0;
    cpu_result_data_o     = '0;
    cpu_result_rd_o       = '0;
    cpu_result_we_o       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_issue_valid_i) begin
          state_d = OFFER;
          idx_d   = '0;
        end
      end

      OFFER: begin
        cp_issue_valid_o = offer_oh;
        if (!cpu_issue_valid_i) begin
          // CPU withdrew an issue before the handshake completed
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (sel_ready) begin
          if (sel_accept) begin
            cpu_issue_ready_o     = 1'b1;
            cpu_issue_accept_o    = 1'b1;
            cpu_issue_writeback_o = sel_wb;
            owner_d               = idx_q;
            id_d                  = cpu_issue_id_i;
            if (cpu_commit_valid_i && (cpu_commit_id_i == cpu_issue_id_i)) begin
              // Commit arriving with the accept skips COMMIT_WAIT entirely
              cp_commit_valid_o = offer_oh;
              state_d           = cpu_commit_kill_i ? IDLE : RESULT_WAIT;
            end else begin
              state_d = COMMIT_WAIT;
            end
          end else if (idx_q == LAST_IDX) begin
            // Every coprocessor declined: complete the handshake as not accepted
            cpu_issue_ready_o = 1'b1;
            state_d           = IDLE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end

      COMMIT_WAIT: begin
        if (cpu_commit_valid_i) begin
          if (cpu_commit_id_i == id_q) begin
            cp_commit_valid_o = owner_oh;
            state_d           = cpu_commit_kill_i ? IDLE : RESULT_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
        if (stray_res) begin
          err_d = 1'b1;
        end
      end

      RESULT_WAIT: begin
        cpu_result_valid_o = own_res_valid;
        cp_result_ready_o  = owner_oh & {NUM_COPROC{cpu_result_ready_i}};
        cpu_result_id_o    = own_res_id;
        cpu_result_data_o  = cp_result_data_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        cpu_result_rd_o    = cp_result_rd_i[int'(owner_q)*5 +: 5];
        cpu_result_we_o    = cp_result_we_i[owner_q];
        if (own_res_valid && cpu_result_ready_i) begin
          state_d = IDLE;
          // Mismatched id is still delivered, but flagged
          if (own_res_id != id_q) begin
            err_d = 1'b1;
          end
        end
        if (stray_res) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      owner_q <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      owner_q <= owner_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_xif_coproc_arbiter.sv
// tb/tb_xif_coproc_arbiter.sv - table-driven self-checking bench for xif_coproc_arbiter
module tb_xif_coproc_arbiter;

  localparam int N  = 2;
  localparam int IW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_issue_valid;
  logic [IW-1:0]   cpu_issue_id;
  logic            cpu_issue_ready, cpu_issue_accept, cpu_issue_writeback;
  logic [N-1:0]    cp_issue_valid, cp_issue_ready, cp_issue_accept, cp_issue_writeback;
  logic            cpu_commit_valid;
  logic [IW-1:0]   cpu_commit_id;
  logic            cpu_commit_kill;
  logic [N-1:0]    cp_commit_valid;
  logic [N-1:0]    cp_result_valid, cp_result_ready;
  logic [N*IW-1:0] cp_result_id;
  logic [N*DW-1:0] cp_result_data;
  logic [N*5-1:0]  cp_result_rd;
  logic [N-1:0]    cp_result_we;
  logic            cpu_result_valid, cpu_result_ready;
  logic [IW-1:0]   cpu_result_id;
  logic [DW-1:0]   cpu_result_data;
  logic [4:0]      cpu_result_rd;
  logic            cpu_result_we;
  logic            busy, err;

  always #5 clk = ~clk;

  // Fixed result payloads: cp0 -> id 3, 0xDEADBEEF, rd 5, we 1; cp1 -> id 7, 0x12345678, rd 9, we 0
  assign cp_result_id   = {4'd7, 4'd3};
  assign cp_result_data = {32'h12345678, 32'hDEADBEEF};
  assign cp_result_rd   = {5'd9, 5'd5};
  assign cp_result_we   = 2'b01;

  xif_coproc_arbiter #(.NUM_COPROC(N), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .cpu_issue_valid_i     (cpu_issue_valid),
    .cpu_issue_id_i        (cpu_issue_id),
    .cpu_issue_ready_o     (cpu_issue_ready),
    .cpu_issue_accept_o    (cpu_issue_accept),
    .cpu_issue_writeback_o (cpu_issue_writeback),
    .cp_issue_valid_o      (cp_issue_valid),
    .cp_issue_ready_i      (cp_issue_ready),
    .cp_issue_accept_i     (cp_issue_accept),
    .cp_issue_writeback_i  (cp_issue_writeback),
    .cpu_commit_valid_i    (cpu_commit_valid),
    .cpu_commit_id_i       (cpu_commit_id),
    .cpu_commit_kill_i     (cpu_commit_kill),
    .cp_commit_valid_o     (cp_commit_valid),
    .cp_result_valid_i     (cp_result_valid),
    .cp_result_ready_o     (cp_result_ready),
    .cp_result_id_i        (cp_result_id),
    .cp_result_data_i      (cp_result_data),
    .cp_result_rd_i        (cp_result_rd),
    .cp_result_we_i        (cp_result_we),
    .cpu_result_valid_o    (cpu_result_valid),
    .cpu_result_ready_i    (cpu_result_ready),
    .cpu_result_id_o       (cpu_result_id),
    .cpu_result_data_o     (cpu_result_data),
    .cpu_result_rd_o       (cpu_result_rd),
    .cpu_result_we_o       (cpu_result_we),
    .busy_o                (busy),
    .err_o                 (err)
  );

  // Packed view of the control outputs: ir ia iwb civ[1:0] ccv[1:0] rrdy[1:0] rvalid busy err
  logic [11:0] outw;
  assign outw = {cpu_issue_ready, cpu_issue_accept, cpu_issue_writeback, cp_issue_valid,
                 cp_commit_valid, cp_result_ready, cpu_result_valid, busy, err};

  logic [41:0] resw;
  assign resw = {cpu_result_id, cpu_result_rd, cpu_result_we, cpu_result_data};

  typedef struct {
    logic        rst;
    logic        iv;
    logic [3:0]  iid;
    logic [1:0]  rdy, acc, wb;
    logic        cv;
    logic [3:0]  cid;
    logic        kill;
    logic [1:0]  rv;
    logic        rr;
    logic [11:0] exp;
    int          eown;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [11:0] E(logic ir, logic ia, logic iwb, logic [1:0] civ, logic [1:0] ccv,
                                    logic [1:0] rrd, logic rv, logic bz, logic er);
    return {ir, ia, iwb, civ, ccv, rrd, rv, bz, er};
  endfunction

  function automatic logic [41:0] res_of(int o);
    if (o == 0) return {4'd3, 5'd5, 1'b1, 32'hDEADBEEF};
    return {4'd7, 5'd9, 1'b0, 32'h12345678};
  endfunction

  task automatic add(logic r, logic iv, logic [3:0] iid, logic [1:0] rdy, logic [1:0] acc, logic [1:0] wb,
                     logic cv, logic [3:0] cid, logic kill, logic [1:0] rv, logic rr,
                     logic [11:0] exp, int eown);
    vec_t v;
    v.rst = r; v.iv = iv; v.iid = iid; v.rdy = rdy; v.acc = acc; v.wb = wb;
    v.cv = cv; v.cid = cid; v.kill = kill; v.rv = rv; v.rr = rr; v.exp = exp; v.eown = eown;
    tv.push_back(v);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic clear_inputs();
    rst = 1'b0; cpu_issue_valid = 1'b0; cpu_issue_id = '0;
    cp_issue_ready = '0; cp_issue_accept = '0; cp_issue_writeback = '0;
    cpu_commit_valid = 1'b0; cpu_commit_id = '0; cpu_commit_kill = 1'b0;
    cp_result_valid = '0; cpu_result_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic got;
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // reset state
    add(0,0,0,0,0,0, 0,0,0, 0,0, 12'h000, 0);
    // cp0 accepts with writeback, id 3, commit then result
    add(0,1,3,2'b11,2'b01,2'b01, 0,0,0, 0,0, 12'h000, 0);
    add(0,1,3,2'b11,2'b01,2'b01, 0,0,0, 0,0, E(1,1,1,2'b01,0,0,0,1,0), 0);
    add(0,0,0,0,0,0, 0,0,0, 0,0, E(0,0,0,0,0,0,0,1,0), 0);
    add(0,0,0,0,0,0, 1,3,0, 0,0, E(0,0,0,0,2'b01,0,0,1,0), 0);
    add(0,0,0,0,0,0, 0,0,0, 2'b01,1, E(0,0,0,0,0,2'b01,1,1,0), 0);
    add(0,0,0,0,0,0, 0,0,0, 0,0, 12'h000, 0);
    // cp0 rejects, cp1 accepts, id 7; result held one cycle by the CPU
    add(0,1,7,2'b11,2'b10,0, 0,0,0, 0,0, 12'h000, 0);
    add(0,1,7,2'b11,2'b10,0, 0,0,0, 0,0, E(0,0,0,2'b01,0,0,0,1,0), 0);
    add(0,1,7,2'b11,2'b10,0, 0,0,0, 0,0, E(1,1,0,2'b10,0,0,0,1,0), 0);
    add(0,0,0,0,0,0, 1,7,0, 0,0, E(0,0,0,0,2'b10,0,0,1,0), 0);
    add(0,0,0,0,0,0, 0,0,0, 2'b10,0, E(0,0,0,0,0,0,1,1,0), 1);
    add(0,0,0,0,0,0, 0,0,0, 2'b10,1, E(0,0,0,0,0,2'b10,1,1,0), 1);
    add(0,0,0,0,0,0, 0,0,0, 0,0, 12'h000, 0);
    // both reject, following commit is not forwarded
    add(0,1,2,2'b11,0,0, 0,0,0, 0,0, 12'h000, 0);
    add(0,1,2,2'b11,0,0, 0,0,0, 0,0, E(0,0,0,2'b01,0,0,0,1,0), 0);
    add(0,1,2,2'b11,0,0, 0,0,0, 0,0, E(1,0,0,2'b10,0,0,0,1,0), 0);
    add(0,0,0,0,0,0, 1,2,0, 0,0, 12'h000, 0);
    // kill: owner result offered early is held, never readied
    add(0,1,5,2'b01,2'b01,0, 0,0,0, 0,0, 12'h000, 0);
    add(0,1,5,2'b01,2'b01,0, 0,0,0, 0,0, E(1,1,0,2'b01,0,0,0,1,0), 0);
    add(0,0,0,0,0,0, 1,5,1, 2'b01,1, E(0,0,0,0,2'b01,0,0,1,0), 0);
    add(0,0,0,0,0,0, 0,0,0, 2'b01,1, 12'h000, 0);
    // commit in the handshake cycle, cp1 owner
    add(0,1,7,2'b11,2'b10,0, 0,0,0, 0,0, 12'h000, 0);
    add(0,1,7,2'b11,2'b10,0, 0,0,0, 0,0, E(0,0,0,2'b01,0,0,0,1,0), 0);
    add(0,1,7,2'b11,2'b10,0, 1,7,0, 0,0, E(1,1,0,2'b10,2'b10,0,0,1,0), 0);
    add(0,0,0,0,0,0, 0,0,0, 2'b10,1, E(0,0,0,0,0,2'b10,1,1,0), 1);
    add(0,0,0,0,0,0, 0,0,0, 0,0, 12'h000, 0);
    // stray result from cp0 while cp1 owns, then reset clears err
    add(0,1,7,2'b11,2'b10,0, 0,0,0, 0,0, 12'h000, 0);
    add(0,1,7,2'b11,2'b10,0, 0,0,0, 0,0, E(0,0,0,2'b01,0,0,0,1,0), 0);
    add(0,1,7,2'b11,2'b10,0, 0,0,0, 0,0, E(1,1,0,2'b10,0,0,0,1,0), 0);
    add(0,0,0,0,0,0, 1,7,0, 0,0, E(0,0,0,0,2'b10,0,0,1,0), 0);
    add(0,0,0,0,0,0, 0,0,0, 2'b01,1, E(0,0,0,0,0,2'b10,0,1,0), 0);
    add(0,0,0,0,0,0, 0,0,0, 0,0, E(0,0,0,0,0,0,0,1,1), 0);
    add(1,0,0,0,0,0, 0,0,0, 0,0, E(0,0,0,0,0,0,0,1,1), 0);
    add(0,0,0,0,0,0, 0,0,0, 0,0, 12'h000, 0);

    foreach (tv[i]) begin
      rst = tv[i].rst; cpu_issue_valid = tv[i].iv; cpu_issue_id = tv[i].iid;
      cp_issue_ready = tv[i].rdy; cp_issue_accept = tv[i].acc; cp_issue_writeback = tv[i].wb;
      cpu_commit_valid = tv[i].cv; cpu_commit_id = tv[i].cid; cpu_commit_kill = tv[i].kill;
      cp_result_valid = tv[i].rv; cpu_result_ready = tv[i].rr;
      #2;
      chk($sformatf("row%0d_ctrl", i), 64'(outw), 64'(tv[i].exp));
      if (tv[i].exp[2]) chk($sformatf("row%0d_result", i), 64'(resw), 64'(res_of(tv[i].eown)));
      step();
    end
    clear_inputs();

    // issue valid withdrawn during OFFER
    cpu_issue_valid = 1'b1; cpu_issue_id = 4'd1;
    #2;
    step();
    cpu_issue_valid = 1'b0;
    #2;
    chk("drop_offer", 64'(cp_issue_valid), 64'(2'b01));
    chk("drop_err_not_yet", 64'(err), 64'(1'b0));
    step();
    #2;
    chk("drop_err_busy", 64'({busy, err}), 64'(2'b01));

    // wrong commit id, then mid-transaction reset blocks forwarding
    rst = 1'b1;
    step();
    rst = 1'b0;
    cpu_issue_valid = 1'b1; cpu_issue_id = 4'd4; cp_issue_ready = 2'b11; cp_issue_accept = 2'b10;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      #2;
      if (cpu_issue_ready) got = 1'b1;
      step();
    end
    chk("issue_hs_wait", 64'(got), 64'(1'b1));
    clear_inputs();
    cpu_commit_valid = 1'b1; cpu_commit_id = 4'd9;
    #2;
    chk("bad_commit_blocked", 64'(cp_commit_valid), 64'(2'b00));
    step();
    cpu_commit_valid = 1'b0;
    #2;
    chk("bad_commit_err", 64'({busy, err}), 64'(2'b11));
    rst = 1'b1;
    step();
    rst = 1'b0;
    cpu_commit_valid = 1'b1; cpu_commit_id = 4'd4; cp_result_valid = 2'b10; cpu_result_ready = 1'b1;
    #2;
    chk("post_reset_ctrl", 64'(outw), 64'(12'h000));
    chk("post_reset_result", 64'(resw), 64'(42'h0));
    step();
    clear_inputs();
    #2;
    chk("post_reset_idle", 64'(outw), 64'(12'h000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
